snapshot_uart_tx: RTL and testbench



---
 rtl/snapshot_uart_tx_pkg.sv | 34 +++
 rtl/snapshot_uart_tx_if.sv | 30 +++
 rtl/uart_baud_tick.sv | 50 +++++
 rtl/snapshot_uart_tx.sv | 152 +++++++++++++++
 tb/tb_snapshot_uart_tx.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snapshot_uart_tx_pkg.sv
// Shared types and constants for the snapshot UART transmitter.
//   state_t           : transmitter FSM state encoding
//   SYNC_BYTE_DEFAULT : default first byte of every frame
//   FRAME_BYTES       : bytes per frame (sync, MSB, LSB)
//   BITS_PER_BYTE     : data bits per UART character
//   SNAP_W            : snapshot width supported by this revision
package snapshot_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned FRAME_BYTES       = 3;
    localparam int unsigned BITS_PER_BYTE     = 8;
    localparam int unsigned SNAP_W            = 16;

    // Selects the frame byte for a given byte index: sync, then MSB, then LSB.
    function automatic logic [7:0] frame_byte(
        input logic [1:0]        idx,
        input logic [SNAP_W-1:0] shadow,
        input logic [7:0]        sync
    );
        case (idx)
            2'd0:    frame_byte = sync;
            2'd1:    frame_byte = shadow[15:8];
            default: frame_byte = shadow[7:0];
        endcase
    endfunction

endpackage

// File: rtl/snapshot_uart_tx_if.sv
// Request/status bundle between a snapshot producer and the UART transmitter.
//   snap_req : capture-and-send request (to transmitter)
//   data_in  : value to snapshot (to transmitter)
//   clr_ovf  : clears the overflow flag (to transmitter)
//   tx       : UART line, idle high (from transmitter)
//   busy     : frame in progress (from transmitter)
//   done     : one-cycle frame-complete pulse (from transmitter)
//   ovf      : sticky dropped-request flag (from transmitter)
interface snapshot_uart_tx_if;
    import snapshot_uart_tx_pkg::*;

    logic              snap_req;
    logic [SNAP_W-1:0] data_in;
    logic              clr_ovf;
    logic              tx;
    logic              busy;
    logic              done;
    logic              ovf;

    modport master (
        output snap_req, data_in, clr_ovf,
        input  tx, busy, done, ovf
    );

    modport slave (
        input  snap_req, data_in, clr_ovf,
        output tx, busy, done, ovf
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator: counts 0..CLKS_PER_BIT-1 while enabled and
// pulses tick during the terminal-count cycle; the count is held at 0
// while disabled.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high
//   en   : count enable
//   tick : registered, high in the cycle the counter sits at terminal count
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_baud_tick: CLKS_PER_BIT must be in 2..65535");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // tick is registered one count early so it lines up with terminal count.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else begin
            tick_d = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
            cnt_d  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/snapshot_uart_tx.sv
// Snapshots a 16-bit value on request and sends it as a 3-byte UART 8N1
// frame: SYNC_BYTE, value[15:8], value[7:0], each LSB first.
//   clk : clock, rising edge
//   rst : synchronous reset, active high
//   bus : slave side of snapshot_uart_tx_if (snap_req/data_in/clr_ovf in,
//         tx/busy/done/ovf out, all outputs registered)
module snapshot_uart_tx
    import snapshot_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 16,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    snapshot_uart_tx_if.slave bus
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("snapshot_uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
    if (DATA_W != SNAP_W) begin : g_bad_dw
        $error("snapshot_uart_tx: DATA_W must be 16");
    end

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [SNAP_W-1:0] shadow_q, shadow_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              tick;
    logic              baud_en;
    logic [7:0]        cur_byte;

    assign baud_en  = (state_q != IDLE);
    assign cur_byte = frame_byte(byte_idx_q, shadow_q, SYNC_BYTE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .en  (baud_en),
        .tick(tick)
    );

    // Next-state logic; tx/busy/done are computed for the edge that enters
    // each state so the registered outputs change together with the state.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        shadow_d   = shadow_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;

        // A dropped request outranks a simultaneous clear.
        if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (bus.snap_req && busy_q) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.snap_req) begin
                    shadow_d   = bus.data_in;
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = cur_byte[0];
                    shift_d   = {1'b0, cur_byte[7:1]};
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'(BITS_PER_BYTE - 1)) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_idx_q < 2'(FRAME_BYTES - 1)) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            shadow_q   <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            shadow_q   <= shadow_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_snapshot_uart_tx.sv
// Self-checking bench for snapshot_uart_tx with CLKS_PER_BIT=4. Expected
// bytes are queued when a request is issued and popped as the tx line is
// decoded.
module tb_snapshot_uart_tx;

    localparam int unsigned CPB      = 4;
    localparam int unsigned HUNT_MAX = 400;

    logic clk;
    logic rst;

    snapshot_uart_tx_if bus ();

    snapshot_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    // Busy-length and done-pulse observer.
    int busy_cur       = 0;
    int busy_last      = 0;
    int done_cnt       = 0;
    logic prev_busy    = 1'b0;
    logic done_prev_busy = 1'b0;

    always @(negedge clk) begin
        if (bus.busy === 1'b1) begin
            busy_cur <= busy_cur + 1;
        end else begin
            if (busy_cur != 0) busy_last <= busy_cur;
            busy_cur <= 0;
        end
        if (bus.done === 1'b1) begin
            done_cnt       <= done_cnt + 1;
            done_prev_busy <= prev_busy;
        end
        prev_busy <= bus.busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Issue a one-cycle request; data_in switches to d_after right after acceptance.
    // Returns at the negedge of the first start-bit cycle.
    task automatic send_req(input logic [15:0] d, input logic [15:0] d_after);
        bus.snap_req = 1'b1;
        bus.data_in  = d;
        exp_q.push_back(8'hA5);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        @(negedge clk);
        bus.snap_req = 1'b0;
        bus.data_in  = d_after;
    endtask

    // Decode one 8N1 character, sampling mid-bit; returns at mid stop bit.
    task automatic decode_byte(output logic [7:0] b, output logic stop_b, output bit ok);
        int n;
        n      = 0;
        ok     = 1'b1;
        b      = 8'h00;
        stop_b = 1'b0;
        while (bus.tx !== 1'b0) begin
            if (n >= int'(HUNT_MAX)) begin
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        repeat (CPB + CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            b[k] = bus.tx;
            repeat (CPB) @(negedge clk);
        end
        stop_b = bus.tx;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.snap_req = 1'b0;
        bus.clr_ovf  = 1'b0;
        bus.data_in  = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.tx, bus.busy, bus.done, bus.ovf} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_cycle%0d: got tx/busy/done/ovf=%b required 1000", i,
                         {bus.tx, bus.busy, bus.done, bus.ovf});
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [7:0] b, e;
        logic sb;
        bit ok;
        int d0, n;
        d0 = done_cnt;
        send_req(16'h1234, 16'h1234);
        checks++;
        if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_start: got tx=%b busy=%b required tx=0 busy=1", bus.tx, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            decode_byte(b, sb, ok);
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            if (!ok || b !== e || sb !== 1'b1) begin
                errors++;
                $display("FAIL single_byte%0d: got %h stop=%b ok=%0d required %h stop=1", i, b, sb, ok, e);
            end
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1 || busy_last != 30 * int'(CPB) || done_prev_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_timing: got done_cnt=%0d busy_len=%0d done_after_busy=%b required %0d %0d 1",
                     done_cnt - d0, busy_last, done_prev_busy, 1, 30 * CPB);
        end
    endtask

    task automatic test_snapshot_stability();
        logic [7:0] b, e;
        logic sb;
        bit ok;
        int n;
        send_req(16'h1234, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            decode_byte(b, sb, ok);
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            if (!ok || b !== e || sb !== 1'b1) begin
                errors++;
                $display("FAIL snapshot_byte%0d: got %h stop=%b ok=%0d required %h stop=1", i, b, sb, ok, e);
            end
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b, e;
        logic sb;
        bit ok;
        int d0, n;
        d0 = done_cnt;
        send_req(16'h5A3C, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            decode_byte(b, sb, ok);
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            if (!ok || b !== e || sb !== 1'b1) begin
                errors++;
                $display("FAIL b2b_first_byte%0d: got %h stop=%b ok=%0d required %h stop=1", i, b, sb, ok, e);
            end
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_seen: got done=%b required 1", bus.done);
        end
        // Request issued during the done cycle.
        send_req(16'h00FF, 16'h00FF);
        checks++;
        if (bus.tx !== 1'b0 || bus.busy !== 1'b1 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: got tx=%b busy=%b ovf=%b required tx=0 busy=1 ovf=0",
                     bus.tx, bus.busy, bus.ovf);
        end
        for (int i = 0; i < 3; i++) begin
            decode_byte(b, sb, ok);
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            if (!ok || b !== e || sb !== 1'b1) begin
                errors++;
                $display("FAIL b2b_second_byte%0d: got %h stop=%b ok=%0d required %h stop=1", i, b, sb, ok, e);
            end
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 2 || bus.ovf !== 1'b0 || busy_last != 30 * int'(CPB)) begin
            errors++;
            $display("FAIL b2b_summary: got done_cnt=%0d ovf=%b busy_len=%0d required 2 0 %0d",
                     done_cnt - d0, bus.ovf, busy_last, 30 * CPB);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b, e;
        logic sb;
        bit ok;
        int d0, n;
        d0 = done_cnt;
        send_req(16'hBEEF, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            decode_byte(b, sb, ok);
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            if (!ok || b !== e || sb !== 1'b1) begin
                errors++;
                $display("FAIL ovf_byte%0d: got %h stop=%b ok=%0d required %h stop=1", i, b, sb, ok, e);
            end
            if (i == 0) begin
                // Dropped request in the stop bit of byte 0.
                bus.snap_req = 1'b1;
                bus.data_in  = 16'h1111;
                @(negedge clk);
                bus.snap_req = 1'b0;
                checks++;
                if (bus.ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_set: got ovf=%b required 1", bus.ovf);
                end
            end else if (i == 1) begin
                // Clear and dropped request together: set wins.
                bus.snap_req = 1'b1;
                bus.clr_ovf  = 1'b1;
                @(negedge clk);
                bus.snap_req = 1'b0;
                bus.clr_ovf  = 1'b0;
                checks++;
                if (bus.ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_set_wins: got ovf=%b required 1", bus.ovf);
                end
            end
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1 || busy_last != 30 * int'(CPB) || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_frame: got done_cnt=%0d busy_len=%0d ovf=%b required 1 %0d 1",
                     done_cnt - d0, busy_last, bus.ovf, 30 * CPB);
        end
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b required 0", bus.ovf);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b, e;
        logic sb;
        bit ok;
        int d0, n;
        d0 = done_cnt;
        send_req(16'hC33C, 16'h0000);
        decode_byte(b, sb, ok);
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (!ok || b !== e) begin
            errors++;
            $display("FAIL rstmid_byte0: got %h ok=%0d required %h", b, ok, e);
        end
        // Move into the data bits of byte 1.
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: got tx=%b busy=%b done=%b required 1 0 0", bus.tx, bus.busy, bus.done);
        end
        rst = 1'b0;
        exp_q.delete();
        repeat (12 * CPB) @(negedge clk);
        checks++;
        if (done_cnt != d0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: got done_cnt=%0d tx=%b busy=%b required 0 1 0",
                     done_cnt - d0, bus.tx, bus.busy);
        end
        send_req(16'h0F0F, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            decode_byte(b, sb, ok);
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            if (!ok || b !== e || sb !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_new_byte%0d: got %h stop=%b ok=%0d required %h stop=1", i, b, sb, ok, e);
            end
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1 || busy_last != 30 * int'(CPB)) begin
            errors++;
            $display("FAIL rstmid_new_frame: got done_cnt=%0d busy_len=%0d required 1 %0d",
                     done_cnt - d0, busy_last, 30 * CPB);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.snap_req = 1'b0;
        bus.clr_ovf  = 1'b0;
        bus.data_in  = 16'h0000;
        test_reset();
        test_single_frame();
        test_snapshot_stability();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d queued bytes required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
